// File: rtl/soft_proc_pkg.sv
// soft_proc_pkg: opcodes, FSM state encoding and instruction field helpers
// shared by the soft_proc_core accumulator processor and its program RAM.
package soft_proc_pkg;

  // Widest instruction word the field helpers accept (4-bit opcode + operand).
  localparam int IW_MAX = 36;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LOD = 4'h1;
  localparam logic [3:0] OP_STR = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_ADI = 4'h8;
  localparam logic [3:0] OP_SUI = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JNZ = 4'hB;
  localparam logic [3:0] OP_JEZ = 4'hC;
  localparam logic [3:0] OP_JNC = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Opcode sits directly above the operand field.
  function automatic logic [3:0] f_opcode(
    input logic [IW_MAX-1:0] w,
    input int                opnd_w
  );
    return w[opnd_w +: 4];
  endfunction

  // Operand field, zero-extended.
  function automatic logic [31:0] f_operand(
    input logic [IW_MAX-1:0] w,
    input int                opnd_w
  );
    logic [IW_MAX-1:0] m;
    m = (IW_MAX'(1) << opnd_w) - IW_MAX'(1);
    return 32'(w & m);
  endfunction

endpackage

// File: rtl/soft_proc_prog_mem.sv
// soft_proc_prog_mem: 2^PC_W x IW program RAM, one synchronous write port
// and one registered read port. Ports: clk, i_we/i_waddr/i_wdata, i_re/i_raddr/o_rdata.
module soft_proc_prog_mem #(
  parameter int PC_W = 4,
  parameter int IW   = 8
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [PC_W-1:0] i_waddr,
  input  logic [IW-1:0]   i_wdata,
  input  logic            i_re,
  input  logic [PC_W-1:0] i_raddr,
  output logic [IW-1:0]   o_rdata
);

  logic [IW-1:0] r_mem [2**PC_W];
  logic [IW-1:0] r_rdata;

  // No reset: contents survive RESET.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/soft_proc_core.sv
// soft_proc_core: parametrised accumulator processor, FETCH/EXEC FSM, inline
// register file and ALU. Ports: SYSCLK/RESET, step/run/pc_acc_clr control,
// manual_en/manual_instr, prog_* RAM load, dbg_addr/dbg_data, pc/acc/flags/status.
module soft_proc_core
  import soft_proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int PC_W   = 4,
  parameter int OPND_W = 4
) (
  input  logic              SYSCLK,
  input  logic              RESET,
  input  logic              step,
  input  logic              run,
  input  logic              pc_acc_clr,
  input  logic              manual_en,
  input  logic [3+OPND_W:0] manual_instr,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [3+OPND_W:0] prog_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              zero,
  output logic              halted,
  output logic              busy
);

  localparam int IW   = 4 + OPND_W;
  localparam int NREG = 2**REG_AW;

  state_t r_state, w_next;

  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_acc;
  logic              r_carry, r_zero, r_man;
  logic [IW-1:0]     r_ir_man;
  logic [DATA_W-1:0] r_rf [NREG];

  logic [IW-1:0]     w_mem_rd, w_ir;
  logic [3:0]        w_op;
  logic [OPND_W-1:0] w_o;
  logic [REG_AW-1:0] w_ridx;
  logic [PC_W-1:0]   w_tgt;
  logic [DATA_W-1:0] w_rv, w_imm, w_b;
  logic [DATA_W:0]   w_sum, w_dif;
  logic              w_we_ok, w_start, w_cont, w_exec;
  logic              w_acc_we, w_c_we, w_c_nx, w_rf_we, w_jmp, w_hlt;
  logic [DATA_W-1:0] w_acc_nx;

  soft_proc_prog_mem #(.PC_W(PC_W), .IW(IW)) u_mem (
    .clk    (SYSCLK),
    .i_we   (w_we_ok),
    .i_waddr(prog_addr),
    .i_wdata(prog_data),
    .i_re   (r_state == FETCH),
    .i_raddr(r_pc),
    .o_rdata(w_mem_rd)
  );

  // Loads only while not executing; a clear takes priority.
  assign w_we_ok = prog_we && !pc_acc_clr &&
                   (r_state == IDLE || r_state == HALT);
  // An accepted RAM write swallows a same-cycle step/run.
  assign w_start = (step || run) && (r_state == IDLE) &&
                   !pc_acc_clr && !w_we_ok;
  assign w_exec  = (r_state == EXEC) && !pc_acc_clr;
  assign w_cont  = w_exec && !w_hlt && run;

  assign w_ir   = r_man ? r_ir_man : w_mem_rd;
  assign w_op   = f_opcode(IW_MAX'(w_ir), OPND_W);
  assign w_o    = OPND_W'(f_operand(IW_MAX'(w_ir), OPND_W));
  assign w_ridx = w_o[REG_AW-1:0];
  assign w_tgt  = w_o[PC_W-1:0];
  assign w_rv   = r_rf[w_ridx];
  assign w_imm  = DATA_W'(w_o);
  assign w_b    = (w_op == OP_ADI || w_op == OP_SUI) ? w_imm : w_rv;
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_b};
  assign w_dif  = {1'b0, r_acc} - {1'b0, w_b};

  always_comb begin
    w_acc_we = 1'b0;
    w_acc_nx = r_acc;
    w_c_we   = 1'b0;
    w_c_nx   = r_carry;
    w_rf_we  = 1'b0;
    w_jmp    = 1'b0;
    w_hlt    = 1'b0;
    unique case (w_op)
      OP_NOP: ;
      OP_LOD: begin
        w_acc_we = 1'b1;
        w_acc_nx = w_rv;
      end
      OP_STR: w_rf_we = 1'b1;
      OP_ADD, OP_ADI: begin
        w_acc_we = 1'b1;
        w_acc_nx = w_sum[DATA_W-1:0];
        w_c_we   = 1'b1;
        w_c_nx   = w_sum[DATA_W];
      end
      OP_SUB, OP_SUI: begin
        w_acc_we = 1'b1;
        w_acc_nx = w_dif[DATA_W-1:0];
        w_c_we   = 1'b1;
        w_c_nx   = w_dif[DATA_W];
      end
      OP_AND: begin
        w_acc_we = 1'b1;
        w_acc_nx = r_acc & w_rv;
      end
      OP_OR: begin
        w_acc_we = 1'b1;
        w_acc_nx = r_acc | w_rv;
      end
      OP_LDI: begin
        w_acc_we = 1'b1;
        w_acc_nx = w_imm;
      end
      OP_JMP: w_jmp = 1'b1;
      OP_JNZ: w_jmp = !r_zero;
      OP_JEZ: w_jmp = r_zero;
      OP_JNC: w_jmp = !r_carry;
      OP_JC:  w_jmp = r_carry;
      OP_HLT: w_hlt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (pc_acc_clr) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:  if (w_start) w_next = FETCH;
        FETCH: w_next = EXEC;
        EXEC: begin
          if (w_hlt)    w_next = HALT;
          else if (run) w_next = FETCH;
          else          w_next = IDLE;
        end
        HALT: ;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
      r_man    <= 1'b0;
      r_ir_man <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH) r_ir_man <= manual_instr;
      if (w_start || w_cont) r_man <= manual_en;
      if (pc_acc_clr) begin
        r_pc    <= '0;
        r_acc   <= '0;
        r_carry <= 1'b0;
        r_zero  <= 1'b1;
      end else if (w_exec) begin
        if (w_acc_we) begin
          r_acc  <= w_acc_nx;
          r_zero <= (w_acc_nx == '0);
        end
        if (w_c_we) r_carry <= w_c_nx;
        // Manual non-jumps leave pc where it was.
        if (w_jmp)                 r_pc <= w_tgt;
        else if (!w_hlt && !r_man) r_pc <= r_pc + PC_W'(1);
      end
    end
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_exec && w_rf_we) begin
      r_rf[w_ridx] <= r_acc;
    end
  end

  assign dbg_data = r_rf[dbg_addr];
  assign pc       = r_pc;
  assign acc      = r_acc;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign halted   = (r_state == HALT);
  assign busy     = (r_state == FETCH) || (r_state == EXEC);

endmodule

// File: tb/tb_soft_proc_core.sv
// tb_soft_proc_core: directed vector bench for soft_proc_core, one 8-bit and
// one 4-bit instance driven from the same stimulus.
module tb_soft_proc_core;

  logic       SYSCLK = 1'b0;
  logic       RESET = 1'b0;
  logic       step = 1'b0, run = 1'b0, pc_acc_clr = 1'b0;
  logic       manual_en = 1'b0, prog_we = 1'b0;
  logic [7:0] manual_instr = '0, prog_data = '0;
  logic [3:0] prog_addr = '0, dbg_addr = '0;

  logic [7:0] d8_dbg, d8_acc;
  logic [3:0] d8_pc;
  logic       d8_c, d8_z, d8_h, d8_b;
  logic [3:0] d4_dbg, d4_acc, d4_pc;
  logic       d4_c, d4_z, d4_h, d4_b;

  int n_run = 0;
  int n_fail = 0;

  always #5 SYSCLK = ~SYSCLK;

  soft_proc_core #(.DATA_W(8), .REG_AW(4), .PC_W(4), .OPND_W(4)) u8 (
    .SYSCLK(SYSCLK), .RESET(RESET), .step(step), .run(run),
    .pc_acc_clr(pc_acc_clr), .manual_en(manual_en),
    .manual_instr(manual_instr), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_addr(dbg_addr), .dbg_data(d8_dbg), .pc(d8_pc), .acc(d8_acc),
    .carry(d8_c), .zero(d8_z), .halted(d8_h), .busy(d8_b)
  );

  soft_proc_core #(.DATA_W(4), .REG_AW(4), .PC_W(4), .OPND_W(4)) u4 (
    .SYSCLK(SYSCLK), .RESET(RESET), .step(step), .run(run),
    .pc_acc_clr(pc_acc_clr), .manual_en(manual_en),
    .manual_instr(manual_instr), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_addr(dbg_addr), .dbg_data(d4_dbg), .pc(d4_pc), .acc(d4_acc),
    .carry(d4_c), .zero(d4_z), .halted(d4_h), .busy(d4_b)
  );

  typedef struct {
    logic [7:0] instr;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic [3:0] pc;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic nclk(input int n);
    for (int i = 0; i < n; i++) @(negedge SYSCLK);
  endtask

  // One step pulse, then wait until the instruction has committed.
  task automatic do_step(input logic man, input logic [7:0] ins);
    manual_en = man;
    manual_instr = ins;
    step = 1'b1;
    nclk(1);
    step = 1'b0;
    nclk(2);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    nclk(1);
    prog_we = 1'b0;
  endtask

  task automatic clr_pulse();
    pc_acc_clr = 1'b1;
    nclk(1);
    pc_acc_clr = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    nclk(2);
    RESET = 1'b0;
    nclk(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt, nchg;
    logic [3:0] prev;

    vt[0]  = '{8'h73, 8'h03, 1'b0, 1'b0, 4'h0};
    vt[1]  = '{8'h95, 8'hFE, 1'b1, 1'b0, 4'h0};
    vt[2]  = '{8'h82, 8'h00, 1'b1, 1'b1, 4'h0};
    vt[3]  = '{8'h77, 8'h07, 1'b1, 1'b0, 4'h0};
    vt[4]  = '{8'h22, 8'h07, 1'b1, 1'b0, 4'h0};
    vt[5]  = '{8'h70, 8'h00, 1'b1, 1'b1, 4'h0};
    vt[6]  = '{8'h12, 8'h07, 1'b1, 1'b0, 4'h0};
    vt[7]  = '{8'h32, 8'h0E, 1'b0, 1'b0, 4'h0};
    vt[8]  = '{8'h42, 8'h07, 1'b0, 1'b0, 4'h0};
    vt[9]  = '{8'h7C, 8'h0C, 1'b0, 1'b0, 4'h0};
    vt[10] = '{8'h52, 8'h04, 1'b0, 1'b0, 4'h0};
    vt[11] = '{8'h62, 8'h07, 1'b0, 1'b0, 4'h0};
    vt[12] = '{8'h43, 8'h07, 1'b0, 1'b0, 4'h0};
    vt[13] = '{8'hA9, 8'h07, 1'b0, 1'b0, 4'h9};
    vt[14] = '{8'hC2, 8'h07, 1'b0, 1'b0, 4'h9};
    vt[15] = '{8'hB4, 8'h07, 1'b0, 1'b0, 4'h4};
    vt[16] = '{8'hE1, 8'h07, 1'b0, 1'b0, 4'h4};
    vt[17] = '{8'hD6, 8'h07, 1'b0, 1'b0, 4'h6};
    vt[18] = '{8'h00, 8'h07, 1'b0, 1'b0, 4'h6};
    vt[19] = '{8'h98, 8'hFF, 1'b1, 1'b0, 4'h6};
    vt[20] = '{8'hE3, 8'hFF, 1'b1, 1'b0, 4'h3};

    // Reset values
    nclk(1);
    do_reset();
    chk("rst_pc", d8_pc, 0);
    chk("rst_acc", d8_acc, 0);
    chk("rst_c", d8_c, 0);
    chk("rst_z", d8_z, 1);
    chk("rst_halt", d8_h, 0);
    chk("rst_busy", d8_b, 0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk($sformatf("rst_R%0d", i), d8_dbg, 0);
    end

    // Count loop on the 4-bit core
    wr(4'd0, 8'h10);
    wr(4'd1, 8'h81);
    wr(4'd2, 8'h20);
    wr(4'd3, 8'hB0);
    wr(4'd4, 8'hFF);
    dbg_addr = 4'd0;
    manual_en = 1'b0;
    run = 1'b1;
    prev = 4'd0;
    exp_cnt = 1;
    nchg = 0;
    for (int i = 0; i < 600; i++) begin
      nclk(1);
      if (d4_dbg !== prev) begin
        chk($sformatf("count_%0d", nchg), d4_dbg, 32'(exp_cnt));
        prev = d4_dbg;
        exp_cnt = (exp_cnt + 1) % 16;
        nchg++;
      end
      if (d4_h) break;
    end
    chk("count_halted", d4_h, 1);
    chk("count_nchg", nchg, 16);
    chk("count_pc", d4_pc, 4);
    chk("count_acc", d4_acc, 0);
    chk("count_c", d4_c, 1);
    chk("count_z", d4_z, 1);
    chk("count_busy", d4_b, 0);
    run = 1'b0;
    nclk(3);
    do_reset();

    // Single step timing
    manual_en = 1'b1;
    manual_instr = 8'h75;
    step = 1'b1;
    nclk(1);
    step = 1'b0;
    chk("ss_busy1", d8_b, 1);
    chk("ss_acc1", d8_acc, 0);
    nclk(1);
    chk("ss_busy2", d8_b, 1);
    chk("ss_acc2", d8_acc, 0);
    nclk(1);
    chk("ss_acc", d8_acc, 5);
    chk("ss_busy3", d8_b, 0);
    chk("ss_pc", d8_pc, 0);

    // Manual instruction table
    for (int i = 0; i < 21; i++) begin
      do_step(1'b1, vt[i].instr);
      chk($sformatf("v%0d_acc", i), d8_acc, vt[i].acc);
      chk($sformatf("v%0d_c", i), d8_c, vt[i].c);
      chk($sformatf("v%0d_z", i), d8_z, vt[i].z);
      chk($sformatf("v%0d_pc", i), d8_pc, vt[i].pc);
    end
    dbg_addr = 4'd2;
    #1;
    chk("tbl_R2", d8_dbg, 7);

    // Abort STR 2 in its EXEC cycle
    do_step(1'b1, 8'h79);
    do_step(1'b1, 8'h22);
    do_step(1'b1, 8'h77);
    manual_instr = 8'h22;
    step = 1'b1;
    nclk(1);
    step = 1'b0;
    nclk(1);
    pc_acc_clr = 1'b1;
    nclk(1);
    pc_acc_clr = 1'b0;
    chk("ab_R2", d8_dbg, 9);
    chk("ab_pc", d8_pc, 0);
    chk("ab_acc", d8_acc, 0);
    chk("ab_busy", d8_b, 0);
    chk("ab_halt", d8_h, 0);

    // Halt, ignored step, load while halted, clear, re-run
    wr(4'd0, 8'h71);
    wr(4'd1, 8'hF0);
    do_step(1'b0, 8'h00);
    chk("hl_acc1", d8_acc, 1);
    chk("hl_pc1", d8_pc, 1);
    do_step(1'b0, 8'h00);
    chk("hl_halted", d8_h, 1);
    chk("hl_busy", d8_b, 0);
    chk("hl_pc2", d8_pc, 1);
    manual_en = 1'b0;
    step = 1'b1;
    nclk(1);
    step = 1'b0;
    chk("hl_stepbusy", d8_b, 0);
    nclk(2);
    chk("hl_still", d8_h, 1);
    chk("hl_pc3", d8_pc, 1);
    wr(4'd0, 8'h76);
    clr_pulse();
    chk("hl_clr_h", d8_h, 0);
    chk("hl_clr_pc", d8_pc, 0);
    do_step(1'b0, 8'h00);
    chk("hl_new_acc", d8_acc, 6);
    chk("hl_new_pc", d8_pc, 1);

    // Write while busy is ignored
    clr_pulse();
    manual_en = 1'b0;
    step = 1'b1;
    nclk(1);
    step = 1'b0;
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = 8'h7B;
    nclk(1);
    prog_we = 1'b0;
    nclk(1);
    chk("bw_acc", d8_acc, 6);
    clr_pulse();
    do_step(1'b0, 8'h00);
    chk("bw_keep", d8_acc, 6);

    // Step together with an accepted write is dropped
    step = 1'b1;
    prog_we = 1'b1;
    prog_addr = 4'd5;
    prog_data = 8'h7A;
    nclk(1);
    step = 1'b0;
    prog_we = 1'b0;
    chk("sw_busy", d8_b, 0);

    // Asynchronous reset mid-FETCH
    clr_pulse();
    do_step(1'b1, 8'h79);
    do_step(1'b1, 8'h25);
    do_step(1'b1, 8'h9A);
    dbg_addr = 4'd5;
    #1;
    chk("rs_pre_R5", d8_dbg, 9);
    chk("rs_pre_c", d8_c, 1);
    manual_en = 1'b0;
    step = 1'b1;
    nclk(1);
    step = 1'b0;
    chk("rs_fetch", d8_b, 1);
    RESET = 1'b1;
    #1;
    chk("rs_pc", d8_pc, 0);
    chk("rs_acc", d8_acc, 0);
    chk("rs_c", d8_c, 0);
    chk("rs_z", d8_z, 1);
    chk("rs_h", d8_h, 0);
    chk("rs_b", d8_b, 0);
    chk("rs_R5", d8_dbg, 0);
    nclk(1);
    RESET = 1'b0;
    nclk(1);
    do_step(1'b0, 8'h00);
    chk("rs_ram", d8_acc, 6);
    chk("rs_ram_pc", d8_pc, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
